// File: rtl/cdc_2phase_pkg.sv
// cdc_2phase_pkg: shared constants and helpers for the two-phase CDC halves
package cdc_2phase_pkg;
  localparam int unsigned MinSyncStages = 2;
  function automatic int unsigned usage_width(input int unsigned depth);
    return ($clog2(depth + 1) < 1) ? 1 : $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/cdc_toggle_sync.sv
// cdc_toggle_sync: multi-flop synchronizer for a toggle signal crossing in
module cdc_toggle_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  (* async_reg = "true", dont_touch = "true" *) logic [SYNC_STAGES-1:0] sync_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  assign q_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/cdc_2phase_src_buf.sv
// cdc_2phase_src_buf: buffered source half of a two-phase toggle clock domain crossing
module cdc_2phase_src_buf
  import cdc_2phase_pkg::*;
#(
  parameter type         T           = logic,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clr_i,
  input  T                              data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          async_req_o,
  input  logic                          async_ack_i,
  output T                              async_data_o,
  output logic [usage_width(DEPTH)-1:0] usage_o,
  output logic                          busy_o
);
  localparam int unsigned UW = usage_width(DEPTH);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  if (DEPTH < 1 || SYNC_STAGES < MinSyncStages) begin : g_param_err
    $error("cdc_2phase_src_buf: DEPTH must be >= 1 and SYNC_STAGES >= 2");
  end
  T mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [UW-1:0] usage_q;
  (* dont_touch = "true" *) logic req_q;
  (* dont_touch = "true" *) T data_src_q;
  logic ack_s, in_flight, push, launch;
  cdc_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (async_ack_i),
    .q_o   (ack_s)
  );
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  always_comb begin
    in_flight = req_q ^ ack_s;
    ready_o   = usage_q != UW'(DEPTH);
    push      = valid_i & ready_o & ~clr_i;
    launch    = ~in_flight & (usage_q != '0) & ~clr_i;
  end
  always_ff @(posedge clk_i)
    if (push) mem[wr_ptr] <= data_i;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      usage_q <= '0;
    end else if (clr_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      usage_q <= '0;
    end else begin
      wr_ptr  <= push ? wrap_inc(wr_ptr) : wr_ptr;
      rd_ptr  <= launch ? wrap_inc(rd_ptr) : rd_ptr;
      usage_q <= usage_q + UW'(push) - UW'(launch);
    end
  // launch state is untouched by clr so the toggle pair stays in lockstep
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      req_q      <= 1'b0;
      data_src_q <= '0;
    end else if (launch) begin
      req_q      <= ~req_q;
      data_src_q <= mem[rd_ptr];
    end
  assign async_req_o  = req_q;
  assign async_data_o = data_src_q;
  assign usage_o      = usage_q;
  assign busy_o       = in_flight;
  a_data_stable: assert property (@(posedge clk_i) disable iff (rst_i) busy_o |=> $stable(async_data_o));
  a_push_ready:  assert property (@(posedge clk_i) disable iff (rst_i) push |-> ready_o);
  a_usage_max:   assert property (@(posedge clk_i) disable iff (rst_i) usage_o <= UW'(DEPTH));
endmodule

// File: tb/tb_cdc_2phase_src_buf.sv
// tb_cdc_2phase_src_buf: directed vector bench for the buffered two-phase source half
module tb_cdc_2phase_src_buf;
  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       c;
    logic       a;
    logic       r;
    logic       q;
    logic [7:0] o;
    logic [2:0] u;
    logic       b;
  } vec_t;
  logic clk = 0, rst = 1;
  logic a_clr = 0, a_valid = 0, a_ready, a_req, a_ack = 0, a_busy;
  logic [7:0] a_din = 0, a_aout;
  logic [2:0] a_usage;
  logic b_valid = 0, b_ready, b_req, b_ack = 0, b_busy;
  logic [7:0] b_din = 0, b_aout;
  logic [1:0] b_usage;
  int passed = 0, total = 0;
  vec_t vq[$];
  logic [7:0] got[$];
  always #5 clk = ~clk;
  cdc_2phase_src_buf #(.T(logic [7:0]), .DEPTH(4), .SYNC_STAGES(2)) u_a (
    .clk_i(clk), .rst_i(rst), .clr_i(a_clr), .data_i(a_din), .valid_i(a_valid),
    .ready_o(a_ready), .async_req_o(a_req), .async_ack_i(a_ack), .async_data_o(a_aout),
    .usage_o(a_usage), .busy_o(a_busy)
  );
  cdc_2phase_src_buf #(.T(logic [7:0]), .DEPTH(3), .SYNC_STAGES(3)) u_b (
    .clk_i(clk), .rst_i(rst), .clr_i(1'b0), .data_i(b_din), .valid_i(b_valid),
    .ready_o(b_ready), .async_req_o(b_req), .async_ack_i(b_ack), .async_data_o(b_aout),
    .usage_o(b_usage), .busy_o(b_busy)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask
  task automatic add(input logic v, input logic [7:0] d, input logic c, input logic a,
                     input logic r, input logic q, input logic [7:0] o, input logic [2:0] u, input logic b);
    vq.push_back('{v, d, c, a, r, q, o, u, b});
  endtask
  task automatic chk_a(input string tag, input logic r, input logic q, input logic [7:0] o,
                       input logic [2:0] u, input logic b);
    chk({tag, " ready"}, 32'(a_ready), 32'(r));
    chk({tag, " req"}, 32'(a_req), 32'(q));
    chk({tag, " data"}, 32'(a_aout), 32'(o));
    chk({tag, " usage"}, 32'(a_usage), 32'(u));
    chk({tag, " busy"}, 32'(a_busy), 32'(b));
  endtask
  // destination-side model for instance b: captures data, acks after a random delay
  initial begin
    int dly;
    logic pend;
    pend = 0;
    dly = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        b_ack = 0;
        pend = 0;
      end else if (!pend && b_req != b_ack) begin
        got.push_back(b_aout);
        dly = $urandom_range(2, 9);
        pend = 1;
      end else if (pend) begin
        dly--;
        if (dly == 0) begin
          b_ack = ~b_ack;
          pend = 0;
        end
      end
    end
  end
  initial begin
    //   v  d      c  a    r  q  o      u  b
    add(1, 8'hA5, 0, 0,   1, 0, 8'h00, 1, 0);
    add(0, 8'h00, 0, 0,   1, 1, 8'hA5, 0, 1);
    add(0, 8'h00, 0, 1,   1, 1, 8'hA5, 0, 1);
    add(0, 8'h00, 0, 1,   1, 1, 8'hA5, 0, 0);
    add(1, 8'h01, 0, 1,   1, 1, 8'hA5, 1, 0);
    add(1, 8'h02, 0, 1,   1, 0, 8'h01, 1, 1);
    add(1, 8'h03, 0, 1,   1, 0, 8'h01, 2, 1);
    add(1, 8'h04, 0, 1,   1, 0, 8'h01, 3, 1);
    add(1, 8'h05, 0, 1,   0, 0, 8'h01, 4, 1);
    add(1, 8'h06, 0, 1,   0, 0, 8'h01, 4, 1);
    add(1, 8'h06, 0, 0,   0, 0, 8'h01, 4, 1);
    add(1, 8'h06, 0, 0,   0, 0, 8'h01, 4, 0);
    add(1, 8'h06, 0, 0,   1, 1, 8'h02, 3, 1);
    add(1, 8'h06, 0, 0,   0, 1, 8'h02, 4, 1);
    add(0, 8'h00, 0, 1,   0, 1, 8'h02, 4, 1);
    add(0, 8'h00, 0, 1,   0, 1, 8'h02, 4, 0);
    add(0, 8'h00, 0, 1,   1, 0, 8'h03, 3, 1);
    add(0, 8'h00, 0, 0,   1, 0, 8'h03, 3, 1);
    add(0, 8'h00, 0, 0,   1, 0, 8'h03, 3, 0);
    add(0, 8'h00, 0, 0,   1, 1, 8'h04, 2, 1);
    add(0, 8'h00, 0, 1,   1, 1, 8'h04, 2, 1);
    add(0, 8'h00, 0, 1,   1, 1, 8'h04, 2, 0);
    add(0, 8'h00, 0, 1,   1, 0, 8'h05, 1, 1);
    add(0, 8'h00, 0, 0,   1, 0, 8'h05, 1, 1);
    add(0, 8'h00, 0, 0,   1, 0, 8'h05, 1, 0);
    add(0, 8'h00, 0, 0,   1, 1, 8'h06, 0, 1);
    add(0, 8'h00, 0, 1,   1, 1, 8'h06, 0, 1);
    add(0, 8'h00, 0, 1,   1, 1, 8'h06, 0, 0);
    add(1, 8'h10, 0, 1,   1, 1, 8'h06, 1, 0);
    add(1, 8'h11, 0, 1,   1, 0, 8'h10, 1, 1);
    add(1, 8'h12, 0, 1,   1, 0, 8'h10, 2, 1);
    add(1, 8'h13, 1, 1,   1, 0, 8'h10, 0, 1);
    add(0, 8'h00, 0, 0,   1, 0, 8'h10, 0, 1);
    add(0, 8'h00, 0, 0,   1, 0, 8'h10, 0, 0);
    add(0, 8'h00, 0, 0,   1, 0, 8'h10, 0, 0);
    add(1, 8'h20, 0, 0,   1, 0, 8'h10, 1, 0);
    add(1, 8'h21, 0, 0,   1, 1, 8'h20, 1, 1);
    add(1, 8'h22, 0, 0,   1, 1, 8'h20, 2, 1);
    add(0, 8'h00, 0, 1,   1, 1, 8'h20, 2, 1);
    add(0, 8'h00, 0, 1,   1, 1, 8'h20, 2, 0);
    add(1, 8'h23, 0, 1,   1, 0, 8'h21, 2, 1);
    add(0, 8'h00, 0, 1,   1, 0, 8'h21, 2, 1);
    #3;
    chk_a("reset", 1, 0, 8'h00, 0, 0);
    @(posedge clk);
    #1 rst = 0;
    foreach (vq[i]) begin
      a_valid = vq[i].v;
      a_din   = vq[i].d;
      a_clr   = vq[i].c;
      a_ack   = vq[i].a;
      @(posedge clk);
      #1;
      chk_a($sformatf("row%0d", i + 1), vq[i].r, vq[i].q, vq[i].o, vq[i].u, vq[i].b);
    end
    a_valid = 0;
    a_clr = 0;
    #3 rst = 1;
    #1;
    chk_a("midreset", 1, 0, 8'h00, 0, 0);
    @(posedge clk);
    #1 rst = 0;
    a_ack = 0;
    for (int i = 0; i < 20; i++) begin
      int w;
      w = 0;
      @(negedge clk);
      while (!b_ready && w < 500) begin
        @(negedge clk);
        w++;
      end
      b_valid = 1;
      b_din = 8'(8'h40 + i);
      @(posedge clk);
      #1 b_valid = 0;
    end
    for (int w = 0; w < 3000 && got.size() < 20; w++) @(posedge clk);
    repeat (20) @(posedge clk);
    chk("wrap count", 32'(got.size()), 32'd20);
    for (int i = 0; i < 20 && i < got.size(); i++)
      chk($sformatf("wrap item%0d", i), 32'(got[i]), 32'(8'h40 + i));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cdc_2phase_src_buf.md
Name: cdc_2phase_src_buf

Overview:
- Source-domain half of a two-phase (toggle) clock domain crossing, with a DEPTH-entry buffer in front of the launch register and a configurable-length ack synchronizer.
- Absorbs back-to-back source traffic while a transfer is in flight.
- Runs entirely in the source clock domain; pairs with the existing two-phase destination half over async_req_o / async_ack_i / async_data_o.

Parameters:
- T, logic: payload type.
- DEPTH, 4: buffer entries ahead of the launch register; legal range >= 1.
- SYNC_STAGES, 2: flops in the async_ack_i synchronizer; legal range >= 2.

Ports:
- clk_i  in  1  source clock.
- rst_i  in  1  asynchronous reset, active-high.
- clr_i  in  1  synchronous flush of buffered, not-yet-launched entries.
- data_i  in  T  payload.
- valid_i  in  1  source handshake valid.
- ready_o  out  1  source handshake ready.
- async_req_o  out  1  toggle request to the destination domain.
- async_ack_i  in  1  toggle acknowledge from the destination domain (asynchronous).
- async_data_o  out  T  launched payload; stable while a transfer is in flight.
- usage_o  out  $clog2(DEPTH+1)  buffered entry count, excluding the in-flight entry.
- busy_o  out  1  transfer in flight (async_req_o != synchronized ack).

Behaviour:
- Reset (rst_i high, async): buffer empty; req_q=0; ack_sync chain all 0; data_src_q='0.
  - Outputs during reset: ready_o=1, async_req_o=0, async_data_o='0, usage_o=0, busy_o=0.
- Ack synchronizer: ack_s = last stage of a SYNC_STAGES-deep flop chain on async_ack_i. No other logic reads async_ack_i.
- in_flight = (req_q != ack_s); busy_o = in_flight.
- Push:
  - Fires on valid_i & ready_o; writes data_i at the tail.
  - ready_o = (usage_o != DEPTH), registered-count based.
  - ready_o does not depend on a same-cycle pop: at full it stays 0 even if a launch occurs that cycle.
- Launch:
  - Condition: !in_flight & buffer not empty & !clr_i.
  - On launch: data_src_q <= head, pop head, req_q <= ~req_q.
  - At most one launch per cycle.
- Latency: push at edge N into an empty buffer with the link idle gives the async_req_o toggle and new async_data_o at edge N+1. usage_o is 1 between edges N and N+1.
- Simultaneous push and launch: allowed when not full; usage_o unchanged.
- async_data_o changes only on a launch edge and never while in_flight. This is the data-stability rule of the crossing.
- Return to idle: after the destination toggles async_ack_i, in_flight drops SYNC_STAGES edges after ack capture. The next launch happens on the following edge.
- Pointers wrap modulo DEPTH; non-power-of-2 DEPTH must work.
- clr_i:
  - Empties the buffer (usage_o=0 next cycle).
  - Blocks launch and push that cycle; ready_o is not forced low, but a push presented with clr_i is discarded.
  - Does NOT touch req_q, ack_s or data_src_q. An in-flight transfer completes normally, so the toggle pair never desynchronizes.
- Reset mid-transfer: the destination half must be reset together with this block. This block makes no recovery attempt.
- Assertions (sim only):
  - DEPTH>=1 and SYNC_STAGES>=2.
  - async_data_o stable while busy_o.
  - No push when !ready_o.
  - usage_o <= DEPTH.

Decomposition:
- cdc_2phase_pkg:
  - MinSyncStages = 2.
  - Function usage_width(depth) returning $clog2(depth+1), with a minimum of 1.
  - Shared later by the buffered destination half.
- Sub-module cdc_toggle_sync: parametrised SYNC_STAGES flop chain with async active-high reset and async_reg/dont_touch attributes. Reused by the destination side.
- Buffer storage and pointers are inline. Launch/ack registers keep dont_touch.
- Constraint (unchanged): max_delay of min(src, dst) period on async_req_o, async_ack_i, async_data_o.

Test Plan:
- Reset:
  - Stimulus: assert rst_i mid-cycle.
  - Response: outputs immediately go to ready_o=1, async_req_o=0, usage_o=0, busy_o=0.
- Single transfer (DEPTH=4, SYNC_STAGES=2):
  - Stimulus: push 0xA5 at edge 0.
  - Response: async_req_o=1 and async_data_o=0xA5 after edge 1, busy_o=1.
  - Then: toggle async_ack_i to 1.
  - Response: busy_o=0 two edges after capture.
- Back-pressure:
  - Stimulus: ack held; push 0x01..0x06.
  - Response: 0x01 launches; 0x02..0x05 buffer; usage_o=4, ready_o=0; the 0x06 push stalls.
  - Then: each ack toggle launches the next value in order 0x02..0x06, one per handshake.
- Flush:
  - Stimulus: 0x10 in flight, 0x11/0x12 buffered; assert clr_i one cycle.
  - Response: usage_o=0, async_data_o stays 0x10, busy_o stays 1.
  - Then: ack toggle. Response: busy_o=0 and no further req toggle.
- Wrap, DEPTH=3, SYNC_STAGES=3:
  - Stimulus: 20 values; destination model acks at random 2-9 cycle delays.
  - Response: all 20 received in order; no loss or duplication; stability assertion never fires.
- Simultaneous push and launch at usage_o=2 (DEPTH=4): usage_o stays 2 and ready_o stays 1.
